// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin scheduler sharing one pair-detector FSM between two requesters
module seq_detect_sched #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             det_clr,
  output logic             det_w,
  input  logic             det_z,
  output logic             done,
  output logic [CW-1:0]    result,
  output logic             result_id
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    count;
  logic [IW-1:0]    idx;
  logic             winner;
  logic             last;
  logic             pick;
  logic [CW-1:0]    z_inc;

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign pick  = (req == 2'b11) ? ~last : req[1];
  assign z_inc = {{(CW-1){1'b0}}, det_z};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sr        <= '0;
      count     <= '0;
      idx       <= '0;
      winner    <= 1'b0;
      last      <= 1'b1;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      det_clr   <= 1'b0;
      det_w     <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_id <= 1'b0;
    end else begin
      det_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            winner  <= pick;
            sr      <= pick ? data1 : data0;
            count   <= '0;
            gnt     <= pick ? 2'b10 : 2'b01;
            busy    <= 1'b1;
            det_clr <= 1'b1;
            det_w   <= 1'b0;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          det_w <= sr[WIDTH-1];
          sr    <= {sr[WIDTH-2:0], 1'b0};
          idx   <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          // After only one bit the detector cannot be asserting, so index 0 is skipped.
          if (idx != '0) count <= count + z_inc;
          if (idx == LAST_IDX) begin
            det_w <= 1'b0;
            state <= S_DRAIN;
          end else begin
            det_w <= sr[WIDTH-1];
            sr    <= {sr[WIDTH-2:0], 1'b0};
            idx   <= idx + IW'(1);
          end
        end
        S_DRAIN: begin
          result    <= count + z_inc;
          result_id <= winner;
          last      <= winner;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - directed self-checking bench for seq_detect_sched with a pair-detector model
module tb_seq_detect_sched;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [1:0] gnt;
  logic       busy;
  logic       det_clr;
  logic       det_w;
  logic       det_z;
  logic       done;
  logic [3:0] result;
  logic       result_id;

  int errors = 0;
  int checks = 0;

  seq_detect_sched #(.WIDTH(8), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .gnt       (gnt),
    .busy      (busy),
    .det_clr   (det_clr),
    .det_w     (det_w),
    .det_z     (det_z),
    .done      (done),
    .result    (result),
    .result_id (result_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pair detector: z is high once the last two bits seen were equal.
  typedef enum logic [2:0] {DA, DB, DC, DD, DE} dstate_t;
  dstate_t dst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       dst <= DA;
    else if (det_clr) dst <= DA;
    else if (!det_w)  dst <= (dst == DB || dst == DC) ? DC : DB;
    else              dst <= (dst == DD || dst == DE) ? DE : DD;
  end

  assign det_z = (dst == DC) || (dst == DE);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    req   = r;
    data0 = d0;
    data1 = d1;
    @(posedge clk);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  task automatic job(input string tag, input logic [1:0] r, input logic [7:0] d0,
                     input logic [7:0] d1, input logic exp_id, input logic [3:0] exp_res);
    int n;
    start_job(r, d0, d1);
    wait_done(n);
    check({tag, "_lat"}, n, 11);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_id"}, result_id, exp_id);
    req = 2'b00;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    req   = 2'b00;
    data0 = 8'h00;
    data1 = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_clr", det_clr, 0);
    check("rst_w", det_w, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    check("rst_id", result_id, 0);
    reset = 1'b1;

    // 0x00 from requester 0, cycle by cycle
    start_job(2'b01, 8'h00, 8'hAA);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check($sformatf("t1_gnt_c%0d", c), gnt, 2'b01);
      check($sformatf("t1_busy_c%0d", c), busy, 1);
      check($sformatf("t1_done_c%0d", c), done, (c == 11));
      check($sformatf("t1_clr_c%0d", c), det_clr, (c == 1));
    end
    check("t1_res", result, 7);
    check("t1_id", result_id, 0);
    req = 2'b00;
    @(negedge clk);
    check("t1_gnt_idle", gnt, 0);
    check("t1_busy_idle", busy, 0);
    check("t1_done_idle", done, 0);
    check("t1_res_hold", result, 7);

    job("ff_r1", 2'b10, 8'h00, 8'hFF, 1'b1, 4'd7);
    job("55_r0", 2'b01, 8'h55, 8'h00, 1'b0, 4'd0);
    job("33_r1", 2'b10, 8'h00, 8'h33, 1'b1, 4'd4);

    // Both requesting continuously: alternate 0,1,0,1
    start_job(2'b11, 8'h33, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_done(n);
      check($sformatf("rr%0d_gap", k), n, (k == 0) ? 11 : 12);
      check($sformatf("rr%0d_id", k), result_id, k % 2);
      check($sformatf("rr%0d_res", k), result, (k % 2 == 1) ? 7 : 4);
    end
    req = 2'b00;

    // Request dropped and data changed mid-job
    start_job(2'b01, 8'h33, 8'h00);
    repeat (3) @(negedge clk);
    req   = 2'b00;
    data0 = 8'h55;
    wait_done(n);
    check("drop_lat", n, 8);
    check("drop_res", result, 4);
    check("drop_id", result_id, 0);

    // Tie with last=0 goes to requester 1; then reset mid-SHIFT
    start_job(2'b11, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    check("pre_rst_gnt", gnt, 2'b10);
    reset = 1'b0;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_busy", busy, 0);
    check("arst_w", det_w, 0);
    check("arst_done", done, 0);
    check("arst_res", result, 0);
    check("arst_id", result_id, 0);
    @(negedge clk);
    check("arst_done2", done, 0);
    data0 = 8'h55;
    data1 = 8'h00;
    reset = 1'b1;
    @(posedge clk);
    wait_done(n);
    check("post_rst_lat", n, 11);
    check("post_rst_id", result_id, 0);
    check("post_rst_res", result, 0);
    req = 2'b00;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler that shares one run/pair sequence-detector FSM between two requesters. Each requester submits a WIDTH-bit pattern. The block clears the detector, serializes the pattern MSB-first onto the detector's `w` input, and counts the cycles in which the detector's `z` output is high. It returns that count with a one-cycle done pulse tagged with the requester id. The block sits between the requester logic and the detector instance and is the only driver of the detector's `w` and clear inputs.

## Interface

- `WIDTH`, 8: pattern length in bits, ≥ 2.
- `CW`, 4: result width; must satisfy 2^CW > WIDTH.
- `clk` in, 1: single clock, rising edge.
- `reset` in, 1: asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req` in, 2: request level per requester; held high until `done` with a matching `result_id`.
- `data0` in, WIDTH: pattern for requester 0; sampled only at the accepting edge.
- `data1` in, WIDTH: pattern for requester 1; sampled only at the accepting edge.
- `gnt` out, 2: one-hot grant; high from the CLEAR cycle through the DONE cycle inclusive.
- `busy` out, 1: high in every state except IDLE.
- `det_clr` out, 1: synchronous clear to the detector, forcing it to its initial state A; high in CLEAR only.
- `det_w` out, 1: serial bit to the detector.
- `det_z` in, 1: detector output; reflects the state registered at the previous edge.
- `done` out, 1: one-cycle pulse in DONE.
- `result` out, CW: count of sampled `det_z`=1; held from DONE until the next DONE.
- `result_id` out, 1: requester served; held alongside `result`.

## Operation

- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- **IDLE**
  - If any `req` bit is high at the edge, pick the winner, load its data into the shift register, clear the count, set `gnt`, and go to CLEAR.
  - Otherwise stay in IDLE.
- **Arbitration (round-robin)**
  - A register `last` records the last requester served; its reset value is 1, so requester 0 wins the first tie.
  - Single request: that requester wins.
  - Both requesting: the requester ≠ `last` wins.
- **CLEAR**: one cycle with `det_clr`=1 and `det_w`=0; then go to SHIFT with bit index 0.
- **SHIFT**: WIDTH cycles.
  - `det_w` = shift-register MSB; shift left every cycle.
  - On every SHIFT cycle except index 0, add `det_z` to the count.
  - After index WIDTH-1, go to DRAIN.
- **DRAIN**: one cycle; `det_w`=0; add `det_z` to the count. Exactly WIDTH samples are taken per job.
- **DONE**: one cycle.
  - `done`=1; `result` and `result_id` update; `last` is set to the winner.
  - Go to IDLE; `gnt` returns to 0 on the next edge.
- **Count arithmetic**: unsigned and saturating-free; the maximum is WIDTH-1, because the detector cannot assert `z` after the first bit.
- **Requester protocol**
  - Dropping `req` mid-job does not abort: the job completes and `done` still pulses.
  - A `req` still high in IDLE after its own `done` starts a new job, subject to round-robin.
- **Reset**
  - Asserting reset in any state aborts immediately; no `done` is produced.
  - Reset values: state IDLE, `gnt`=0, `busy`=0, `det_clr`=0, `det_w`=0, `done`=0, `result`=0, `result_id`=0, `last`=1.

## Timing

- Accepting edge = edge 0.
  - CLEAR occupies cycle 1.
  - SHIFT occupies cycles 2 through WIDTH+1.
  - DRAIN occupies cycle WIDTH+2.
  - DONE occupies cycle WIDTH+3, which is 11 for WIDTH=8.
- Back-to-back operation: IDLE takes one cycle, so the earliest next acceptance is edge WIDTH+4. Throughput is one job per WIDTH+4 cycles.
- `det_z` is sampled at the edge ending each SHIFT cycle with index ≥ 1 and at the edge ending DRAIN.
- `data0`/`data1` changes after edge 0 have no effect on the current job.
- All outputs are registered; no combinational path from `req` or `det_z` to any output.

## Test plan

- **Pattern 0x00 from requester 0, paired with a real detector instance**
  - `done` at cycle 11 with `result`=7 and `result_id`=0.
  - `gnt`=01 in cycles 1–11.
- **Pattern 0xFF from requester 1**: `result`=7, `result_id`=1.
- **Patterns 0x55 and 0x33**: `result`=0 and `result`=4 respectively.
- **Both `req` high continuously, data0=0x33, data1=0x00**
  - Served in order 0, 1, 0, 1.
  - `done` pulses 12 cycles apart.
  - Results alternate 4 and 7.
- **`req[0]` dropped in cycle 3, or `data0` changed mid-job**: the job still completes with the original pattern's result.
- **Reset asserted in SHIFT cycle 5**
  - All outputs are 0 immediately, with no `done`.
  - After release, requester 0 wins the first tie.
